// File: rtl/lsu_timer.sv
// lsu_timer: memory-mapped timer on the LSU bus (counter, compare match, sticky status, irq).
// Define TIMER_CAPTURE_EN to add the synchronised external capture register at offset 0x10.
module lsu_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7100,
    parameter int          PRESC_W   = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic        i_lsu_wren,
    input  logic        i_capture,
    output logic        o_hit,
    output logic [31:0] o_ld_data,
    output logic        o_irq
);
    logic               r_en, r_auto, r_irq_en, r_match;
    logic [PRESC_W-1:0] r_presc, r_psc;
    logic [31:0]        r_count, r_compare;
    logic [2:0]         w_off;
    logic               w_wr, w_ctrl_wr, w_count_wr, w_cmp_wr, w_stat_wr;
    logic               w_tick, w_match, w_cap_flag, w_unused;
    logic [31:0]        w_ctrl, w_cap_rd;

    assign o_hit      = i_lsu_addr[31:5] == BASE_ADDR[31:5];
    assign w_off      = i_lsu_addr[4:2];
    assign w_wr       = i_lsu_wren & o_hit;
    assign w_ctrl_wr  = w_wr & (w_off == 3'd0);
    assign w_count_wr = w_wr & (w_off == 3'd1);
    assign w_cmp_wr   = w_wr & (w_off == 3'd2);
    assign w_stat_wr  = w_wr & (w_off == 3'd3);
    assign w_tick     = r_en & (r_psc == r_presc);
    // A COUNT store in the same cycle suppresses both increment and match check.
    assign w_match    = w_tick & ~w_count_wr & (r_count == r_compare);
    assign w_ctrl     = {{(24-PRESC_W){1'b0}}, r_presc, 5'b0, r_irq_en, r_auto, r_en};
    assign o_irq      = r_match & r_irq_en;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_en      <= 1'b0;
            r_auto    <= 1'b0;
            r_irq_en  <= 1'b0;
            r_presc   <= '0;
            r_psc     <= '0;
            r_count   <= '0;
            r_compare <= 32'hFFFF_FFFF;
            r_match   <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_en     <= i_st_data[0];
                r_auto   <= i_st_data[1];
                r_irq_en <= i_st_data[2];
                r_presc  <= i_st_data[8 +: PRESC_W];
            end
            r_psc <= (w_ctrl_wr || !r_en || w_tick) ? '0 : r_psc + 1'b1;
            if (w_count_wr)
                r_count <= i_st_data;
            else if (w_tick)
                r_count <= (w_match && r_auto) ? 32'd0 : r_count + 32'd1;
            if (w_cmp_wr)
                r_compare <= i_st_data;
            r_match <= w_match | (r_match & ~(w_stat_wr & i_st_data[0]));
        end
    end

`ifdef TIMER_CAPTURE_EN
    logic [2:0]  r_sync;
    logic [31:0] r_capture;
    logic        r_cap;
    logic        w_cap_set;

    // r_sync[1:0] is the synchroniser, r_sync[2] the edge-detect history.
    assign w_cap_set  = r_sync[1] & ~r_sync[2];
    assign w_cap_rd   = r_capture;
    assign w_cap_flag = r_cap;
    assign w_unused   = &{1'b0, i_lsu_addr[1:0]};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync    <= '0;
            r_capture <= '0;
            r_cap     <= 1'b0;
        end else begin
            r_sync <= {r_sync[1:0], i_capture};
            if (w_cap_set)
                r_capture <= r_count;
            r_cap <= w_cap_set | (r_cap & ~(w_stat_wr & i_st_data[1]));
        end
    end
`else
    assign w_cap_rd   = '0;
    assign w_cap_flag = 1'b0;
    assign w_unused   = &{1'b0, i_capture, i_lsu_addr[1:0]};
`endif

    always_comb begin
        o_ld_data = !o_hit          ? 32'd0 :
                    w_off == 3'd0   ? w_ctrl :
                    w_off == 3'd1   ? r_count :
                    w_off == 3'd2   ? r_compare :
                    w_off == 3'd3   ? {30'd0, w_cap_flag, r_match} :
                    w_off == 3'd4   ? w_cap_rd : 32'd0;
    end
endmodule

// File: tb/tb_lsu_timer.sv
// tb_lsu_timer: directed stimulus with a read scoreboard checked by a negedge monitor.
module tb_lsu_timer;
    localparam logic [31:0] B = 32'h0000_7100;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] addr = '0, wdata = '0, ld_data;
    logic        wren = 1'b0, cap = 1'b0, hit, irq, rd_req = 1'b0;
    int          n_cmp = 0, n_fail = 0;

    typedef struct {
        logic [31:0] d;
        logic        hit;
        logic        irq;
        string       nm;
    } exp_t;
    exp_t q[$];

    lsu_timer dut (
        .i_clk(clk), .i_reset(rst), .i_lsu_addr(addr), .i_st_data(wdata),
        .i_lsu_wren(wren), .i_capture(cap), .o_hit(hit), .o_ld_data(ld_data), .o_irq(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_req) begin
            if (q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL scoreboard_empty: read with no expected entry");
            end else begin
                exp_t e;
                e = q.pop_front();
                n_cmp++;
                if (ld_data !== e.d) begin
                    n_fail++;
                    $display("FAIL %s data: got %h expected %h", e.nm, ld_data, e.d);
                end
                n_cmp++;
                if (hit !== e.hit) begin
                    n_fail++;
                    $display("FAIL %s hit: got %b expected %b", e.nm, hit, e.hit);
                end
                n_cmp++;
                if (irq !== e.irq) begin
                    n_fail++;
                    $display("FAIL %s irq: got %b expected %b", e.nm, irq, e.irq);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wren = 1'b1;
        step();
        wren = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic h,
                      input logic i, input string nm);
        addr = a;
        q.push_back('{d, h, i, nm});
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        rd(B + 0, 32'd0, 1, 0, "rst_ctrl");
        rd(B + 4, 32'd0, 1, 0, "rst_count");
        rd(B + 8, 32'hFFFF_FFFF, 1, 0, "rst_compare");
        rd(B + 12, 32'd0, 1, 0, "rst_status");
        rd(B + 16, 32'd0, 1, 0, "rst_capture");

        wr(B + 8, 32'd5);
        wr(B + 0, 32'h7);
        for (int k = 0; k < 6; k++) rd(B + 4, k, 1, 0, $sformatf("auto_count%0d", k));
        rd(B + 4, 32'd0, 1, 1, "auto_reload");
        rd(B + 12, 32'd1, 1, 1, "auto_match");
        rd(B + 0, 32'h7, 1, 1, "ctrl_readback");
        wr(B + 0, 32'h0);
        wr(B + 12, 32'h1);

        wr(B + 0, 32'h301);
        wr(B + 4, 32'd0);
        repeat (40) step();
        rd(B + 4, 32'd10, 1, 0, "presc_count");
        rd(B + 0, 32'h301, 1, 0, "presc_ctrl");

        wr(B + 0, 32'h0);
        wr(B + 8, 32'd3);
        wr(B + 12, 32'h1);
        rd(B + 12, 32'd0, 1, 0, "w1c_clear0");
        wr(B + 4, 32'hFFFF_FFFE);
        wr(B + 0, 32'h1);
        rd(B + 4, 32'hFFFF_FFFE, 1, 0, "wrap_fe");
        rd(B + 4, 32'hFFFF_FFFF, 1, 0, "wrap_ff");
        for (int k = 0; k < 4; k++) rd(B + 4, k, 1, 0, $sformatf("wrap_count%0d", k));
        rd(B + 12, 32'd1, 1, 0, "wrap_match");
        wr(B + 12, 32'h1);
        rd(B + 12, 32'd0, 1, 0, "w1c_clear1");
        wr(B + 4, 32'd3);
        wr(B + 12, 32'h1);
        rd(B + 12, 32'd1, 1, 0, "w1c_set_wins");
        rd(B + 4, 32'd5, 1, 0, "after_rematch");

        wr(B + 12, 32'h1);
        wr(B + 4, 32'd100);
        rd(B + 4, 32'd100, 1, 0, "store_wins");
        rd(B + 4, 32'd101, 1, 0, "store_then_inc");
        wr(B + 4, 32'd50);
        wr(B + 8, 32'd50);
        rd(B + 12, 32'd0, 1, 0, "cmp_old_used");
        rd(B + 8, 32'd50, 1, 0, "cmp_readback");

        wr(B + 32'h40, 32'h6);
        rd(B + 32'h40, 32'd0, 0, 0, "miss_read");
        rd(B + 0, 32'h1, 1, 0, "miss_ctrl_kept");
        rd(B + 8, 32'd50, 1, 0, "miss_cmp_kept");
        rd(B + 32'h14, 32'd0, 1, 0, "unmapped_off");

        wr(B + 4, 32'd20);
        cap = 1'b1;
        step();
        cap = 1'b0;
        step();
        step();
`ifdef TIMER_CAPTURE_EN
        rd(B + 16, 32'd22, 1, 0, "capture_val");
        rd(B + 12, 32'd2, 1, 0, "capture_flag");
        wr(B + 12, 32'h2);
        rd(B + 12, 32'd0, 1, 0, "capture_w1c");
`else
        rd(B + 16, 32'd0, 1, 0, "capture_absent");
        rd(B + 12, 32'd0, 1, 0, "capture_flag_absent");
`endif

        rst = 1'b1;
        wr(B + 4, 32'd77);
        rst = 1'b0;
        rd(B + 4, 32'd0, 1, 0, "midrst_count");
        rd(B + 0, 32'd0, 1, 0, "midrst_ctrl");
        rd(B + 8, 32'hFFFF_FFFF, 1, 0, "midrst_compare");

        step();
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
